dmem_access: RTL and testbench

Memory-stage data-bus sequencer for the five-stage MIPS pipeline. Takes the load/store in the M stage, issues it on the data bus with byte strobes, and waits for the address and data handshakes. It aligns and extends load data, then produces `d_data_ok`, the signal the hazard unit uses to stall F/D/E/M and flush W. It sits between the EX/MEM pipeline register and the data-bus port of the core.

---
 rtl/dmem_access.sv | 151 +++++++++++++++
 tb/tb_dmem_access.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access.sv
// Memory-stage data-bus sequencer: issues the M-stage load/store with byte strobes,
// waits for the address/data handshakes and returns aligned, extended load data.
module dmem_access (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic        write,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        advance,
    output logic        dreq_valid,
    output logic [31:0] dreq_addr,
    output logic [1:0]  dreq_size,
    output logic [3:0]  dreq_strobe,
    output logic [31:0] dreq_data,
    input  logic        dresp_addr_ok,
    input  logic        dresp_data_ok,
    input  logic [31:0] dresp_data,
    output logic        d_data_ok,
    output logic [31:0] rdata,
    output logic        misaligned
);

    typedef enum logic [1:0] {StIdle, StWaitData, StDone} state_t;

    state_t      r_state;
    logic [31:0] r_rdata_q;
    logic [1:0]  r_size;
    logic        r_sign_ext;
    logic [1:0]  r_off;
    logic        r_write;

    logic        w_misaligned;
    logic        w_accept;
    logic [31:0] w_ext_live;
    logic [31:0] w_ext_lat;

    // Extract the addressed byte/half from the raw word and extend; stores yield 0.
    function automatic logic [31:0] f_extract(input logic [31:0] data, input logic [1:0] sz,
                                              input logic sext, input logic [1:0] off,
                                              input logic wr);
        logic [31:0] sh;
        sh = data >> {off, 3'b000};
        if (wr) begin
            return 32'h0;
        end
        case (sz)
            2'd0:    return {{24{sext & sh[7]}}, sh[7:0]};
            2'd1:    return {{16{sext & sh[15]}}, sh[15:0]};
            default: return data;
        endcase
    endfunction

    assign w_misaligned = ((size == 2'd1) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
    assign misaligned   = w_misaligned;

    assign dreq_valid = (r_state == StIdle) && valid && !w_misaligned && !reset;
    assign dreq_addr  = addr;
    assign dreq_size  = size;
    assign w_accept   = dreq_valid && dresp_addr_ok;

    always_comb begin
        dreq_strobe = 4'h0;
        dreq_data   = wdata;
        case (size)
            2'd0: begin
                dreq_strobe = 4'b0001 << addr[1:0];
                dreq_data   = {4{wdata[7:0]}};
            end
            2'd1: begin
                dreq_strobe = 4'b0011 << addr[1:0];
                dreq_data   = {2{wdata[15:0]}};
            end
            default: dreq_strobe = 4'hf;
        endcase
        if (!write) begin
            dreq_strobe = 4'h0;
        end
    end

    assign w_ext_live = f_extract(dresp_data, size, sign_ext, addr[1:0], write);
    assign w_ext_lat  = f_extract(dresp_data, r_size, r_sign_ext, r_off, r_write);

    always_comb begin
        rdata     = 32'h0;
        d_data_ok = !valid || w_misaligned;
        unique case (r_state)
            StIdle: begin
                if (w_accept && dresp_data_ok) begin
                    rdata     = w_ext_live;
                    d_data_ok = 1'b1;
                end
            end
            StWaitData: begin
                if (dresp_data_ok) begin
                    rdata     = w_ext_lat;
                    d_data_ok = 1'b1;
                end
            end
            StDone: begin
                rdata     = r_rdata_q;
                d_data_ok = 1'b1;
            end
            default: ;
        endcase
    end

    // DONE holds the result so a stalled instruction is not reissued on the bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_rdata_q  <= 32'h0;
            r_size     <= 2'd0;
            r_sign_ext <= 1'b0;
            r_off      <= 2'd0;
            r_write    <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_size     <= size;
                        r_sign_ext <= sign_ext;
                        r_off      <= addr[1:0];
                        r_write    <= write;
                        if (dresp_data_ok) begin
                            r_rdata_q <= w_ext_live;
                            r_state   <= advance ? StIdle : StDone;
                        end else begin
                            r_state <= StWaitData;
                        end
                    end
                end
                StWaitData: begin
                    if (dresp_data_ok) begin
                        r_rdata_q <= w_ext_lat;
                        r_state   <= advance ? StIdle : StDone;
                    end
                end
                StDone: begin
                    if (advance) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access.sv
// Self-checking bench for dmem_access: directed handshake scenarios, then random traffic
// against a byte-array memory model with scoreboard queues for requests and results.
module tb_dmem_access;

    logic        clk = 1'b0;
    logic        reset, valid, write, sign_ext, advance;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        dreq_valid;
    logic [31:0] dreq_addr;
    logic [1:0]  dreq_size;
    logic [3:0]  dreq_strobe;
    logic [31:0] dreq_data;
    logic        dresp_addr_ok, dresp_data_ok;
    logic [31:0] dresp_data;
    logic        d_data_ok;
    logic [31:0] rdata;
    logic        misaligned;

    always #5 clk = ~clk;

    dmem_access dut (
        .clk           (clk),
        .reset         (reset),
        .valid         (valid),
        .write         (write),
        .size          (size),
        .sign_ext      (sign_ext),
        .addr          (addr),
        .wdata         (wdata),
        .advance       (advance),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_addr_ok (dresp_addr_ok),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data),
        .d_data_ok     (d_data_ok),
        .rdata         (rdata),
        .misaligned    (misaligned)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
    } res_t;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic        wr;
    } req_t;

    res_t        exp_res[$];
    req_t        exp_req[$];
    logic [7:0]  mem8[256];
    logic [31:0] rmem[64];

    int n_chk = 0;
    int n_pass = 0;
    int n_req = 0;
    int n_req_exp = 0;
    logic rsp_auto = 1'b0;
    logic mon_en = 1'b0;
    int rsp_wait = 0;
    int acc_delay = 0;
    int rsp_idx;
    int rsp_dd;
    logic [31:0] rsp_word;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Bus slave: random accept delay 0..2, random data delay 0..3 after accept.
    initial begin
        forever begin
            @(negedge clk);
            if (rsp_auto) begin
                dresp_addr_ok = 1'b0;
                dresp_data_ok = 1'b0;
                if (rsp_wait > 0) begin
                    rsp_wait--;
                    if (rsp_wait == 0) begin
                        dresp_data_ok = 1'b1;
                        dresp_data    = rsp_word;
                    end
                end else if (dreq_valid) begin
                    if (acc_delay > 0) begin
                        acc_delay--;
                    end else begin
                        rsp_idx = int'(dreq_addr[7:2]);
                        if (write) begin
                            for (int k = 0; k < 4; k++)
                                if (dreq_strobe[k]) rmem[rsp_idx][8*k+:8] = dreq_data[8*k+:8];
                            rsp_word = $urandom;
                        end else begin
                            rsp_word = rmem[rsp_idx];
                        end
                        dresp_addr_ok = 1'b1;
                        rsp_dd = int'($urandom % 4);
                        if (rsp_dd == 0) begin
                            dresp_data_ok = 1'b1;
                            dresp_data    = rsp_word;
                        end else begin
                            rsp_wait = rsp_dd;
                        end
                        acc_delay = int'($urandom % 3);
                    end
                end
            end
        end
    end

    // Monitor: checks each accepted request and each retiring result against the queues.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                if (dreq_valid && dresp_addr_ok) begin
                    n_req++;
                    if (exp_req.size() == 0) begin
                        chk("unexpected_request", dreq_addr, 32'h0 ^ ~dreq_addr);
                    end else begin
                        req_t q;
                        q = exp_req.pop_front();
                        chk("req_addr", dreq_addr, q.addr);
                        chk("req_size", 32'(dreq_size), 32'(q.size));
                        chk("req_strobe", 32'(dreq_strobe), 32'(q.strobe));
                        if (q.wr) chk("req_data", dreq_data, q.data);
                    end
                end
                if (valid && d_data_ok && advance) begin
                    if (exp_res.size() == 0) begin
                        chk("unexpected_result", rdata, 32'h0 ^ ~rdata);
                    end else begin
                        res_t r;
                        r = exp_res.pop_front();
                        chk("rdata", rdata, r.rdata);
                        chk("misaligned", 32'(misaligned), 32'(r.mis));
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1; valid = 1'b0; write = 1'b0; size = 2'd0; sign_ext = 1'b0;
        addr = 32'h0; wdata = 32'h0; advance = 1'b0;
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 32'h0;
        for (int i = 0; i < 256; i++) mem8[i] = 8'($urandom);
        for (int i = 0; i < 64; i++)
            rmem[i] = {mem8[4*i+3], mem8[4*i+2], mem8[4*i+1], mem8[4*i]};

        // Reset: no request even with a valid aligned op present.
        @(negedge clk);
        valid = 1'b1; size = 2'd2; addr = 32'h100;
        #1;
        chk("reset_dreq_valid", 32'(dreq_valid), 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        next_cycle();
        reset = 1'b0; valid = 1'b0;
        #1;
        chk("idle_d_data_ok", 32'(d_data_ok), 32'h1);

        // Zero-latency word load.
        valid = 1'b1; write = 1'b0; size = 2'd2; addr = 32'h100;
        dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("t1_dreq_valid", 32'(dreq_valid), 32'h1);
        chk("t1_strobe", 32'(dreq_strobe), 32'h0);
        chk("t1_d_data_ok", 32'(d_data_ok), 32'h1);
        chk("t1_rdata", rdata, 32'hDEADBEEF);
        advance = 1'b1;
        next_cycle();
        advance = 1'b0; valid = 1'b0; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;

        // Signed byte load at 0x103, data three cycles after accept, then held in DONE.
        valid = 1'b1; size = 2'd0; sign_ext = 1'b1; addr = 32'h103; dresp_addr_ok = 1'b1;
        @(negedge clk);
        chk("t2_c0_dreq_valid", 32'(dreq_valid), 32'h1);
        chk("t2_c0_d_data_ok", 32'(d_data_ok), 32'h0);
        next_cycle();
        dresp_addr_ok = 1'b0;
        for (int c = 1; c < 3; c++) begin
            @(negedge clk);
            chk("t2_wait_d_data_ok", 32'(d_data_ok), 32'h0);
            chk("t2_wait_dreq_valid", 32'(dreq_valid), 32'h0);
            next_cycle();
        end
        dresp_data_ok = 1'b1; dresp_data = 32'h80123456;
        @(negedge clk);
        chk("t2_c3_d_data_ok", 32'(d_data_ok), 32'h1);
        chk("t2_c3_rdata", rdata, 32'hFFFFFF80);
        next_cycle();
        dresp_data_ok = 1'b0; dresp_data = 32'h0;
        @(negedge clk);
        chk("t2_done_rdata", rdata, 32'hFFFFFF80);
        chk("t2_done_d_data_ok", 32'(d_data_ok), 32'h1);
        chk("t2_done_no_reissue", 32'(dreq_valid), 32'h0);
        advance = 1'b1;
        next_cycle();
        advance = 1'b0; valid = 1'b0; sign_ext = 1'b0;

        // Half store at 0x202 with accept delayed two cycles.
        valid = 1'b1; write = 1'b1; size = 2'd1; addr = 32'h202; wdata = 32'h0000ABCD;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("t3_dreq_valid", 32'(dreq_valid), 32'h1);
            chk("t3_strobe", 32'(dreq_strobe), 32'hC);
            chk("t3_data", dreq_data, 32'hABCDABCD);
            chk("t3_d_data_ok", 32'(d_data_ok), 32'h0);
            next_cycle();
        end
        dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1;
        @(negedge clk);
        chk("t3_c2_dreq_valid", 32'(dreq_valid), 32'h1);
        chk("t3_c2_d_data_ok", 32'(d_data_ok), 32'h1);
        chk("t3_store_rdata", rdata, 32'h0);
        advance = 1'b1;
        next_cycle();
        advance = 1'b0; valid = 1'b0; write = 1'b0; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;

        // Misaligned word load.
        valid = 1'b1; size = 2'd2; addr = 32'h101;
        #1;
        chk("t4_misaligned", 32'(misaligned), 32'h1);
        chk("t4_dreq_valid", 32'(dreq_valid), 32'h0);
        chk("t4_d_data_ok", 32'(d_data_ok), 32'h1);
        chk("t4_rdata", rdata, 32'h0);
        next_cycle();
        valid = 1'b0;

        // Reset while waiting for data; stale response must be ignored.
        valid = 1'b1; size = 2'd2; addr = 32'h40; dresp_addr_ok = 1'b1;
        next_cycle();
        dresp_addr_ok = 1'b0;
        @(negedge clk);
        chk("t5_wait_d_data_ok", 32'(d_data_ok), 32'h0);
        reset = 1'b1; dresp_data_ok = 1'b1; dresp_data = 32'h12345678;
        #1;
        chk("t5_reset_dreq_valid", 32'(dreq_valid), 32'h0);
        chk("t5_reset_ignores_resp", 32'(d_data_ok), 32'h0);
        next_cycle();
        valid = 1'b0; reset = 1'b0;
        next_cycle();
        dresp_data_ok = 1'b0; valid = 1'b1;
        @(negedge clk);
        chk("t5_reissue_from_idle", 32'(dreq_valid), 32'h1);
        chk("t5_no_stale_done", 32'(d_data_ok), 32'h0);
        dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 32'hCAFEF00D;
        #1;
        chk("t5_rdata", rdata, 32'hCAFEF00D);
        advance = 1'b1;
        next_cycle();
        advance = 1'b0; valid = 1'b0; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;

        // Random traffic against the byte-array model.
        rsp_auto = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a, wd, ev;
            logic [1:0]  sz;
            logic        wr, se;
            int          n, b, hold, t;
            res_t        r;
            req_t        q;
            wr = 1'($urandom % 2);
            sz = 2'($urandom % 4);
            se = 1'($urandom % 2);
            a  = $urandom;
            wd = $urandom;
            n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            if ($urandom % 4 != 0) a = a & ~32'(n - 1);
            r.mis   = (int'(a[1:0]) % n) != 0;
            r.rdata = 32'h0;
            if (!r.mis) begin
                q.addr = a; q.size = sz; q.wr = wr; q.strobe = 4'h0; q.data = 32'h0;
                for (int k = 0; k < 4; k++) q.data[8*k+:8] = wd[8*(k%n)+:8];
                ev = 32'h0;
                for (int k = 0; k < n; k++) begin
                    b = int'(a[7:0]) + k;
                    if (wr) begin
                        q.strobe[int'(a[1:0]) + k] = 1'b1;
                        mem8[b] = wd[8*k+:8];
                    end else begin
                        ev = ev | (32'(mem8[b]) << (8 * k));
                    end
                end
                if (!wr && se && n < 4 && ev[8*n-1]) ev = ev | (32'hFFFFFFFF << (8 * n));
                if (!wr) r.rdata = ev;
                exp_req.push_back(q);
                n_req_exp++;
            end
            exp_res.push_back(r);

            valid = 1'b1; write = wr; size = sz; sign_ext = se; addr = a; wdata = wd;
            t = 0;
            forever begin
                @(negedge clk);
                #1;
                if (d_data_ok) break;
                t++;
                if (t > 30) begin
                    $display("FAIL op_timeout: got d_data_ok=0 for %0d cycles expected completion", t);
                    $fatal(1, "op timeout");
                end
            end
            hold = ($urandom % 3 == 0) ? int'($urandom % 3) : 0;
            repeat (hold) begin
                @(negedge clk);
                #1;
            end
            advance = 1'b1;
            next_cycle();
            advance = 1'b0;
            if ($urandom % 3 == 0) begin
                valid = 1'b0;
                addr  = $urandom;
                repeat ($urandom % 3) next_cycle();
            end
        end
        valid = 1'b0;
        repeat (4) next_cycle();
        mon_en = 1'b0;
        chk("req_count", 32'(n_req), 32'(n_req_exp));
        chk("req_queue_empty", 32'(exp_req.size()), 32'h0);
        chk("res_queue_empty", 32'(exp_res.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
